qft3_prob_readout: RTL

- Downstream consumer of the 3-qubit QFT pipeline's final 8-amplitude state vector.
- Accepts one full vector per handshake, computes |amp|² per basis state using one shared squarer (one index per cycle), and tracks total power and argmax.
- Streams the eight probabilities out serially under valid/ready backpressure.
- Feeds the measurement/readout logic and the host interface.

---
 rtl/qft3_prob_readout_pkg.sv | 19 +
 rtl/complex_mag_sq.sv | 23 ++
 rtl/qft3_prob_readout.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/qft3_prob_readout_pkg.sv
// Shared widths and FSM encoding for the QFT probability readout block.
// TOTAL_WIDTH is the pipeline-wide amplitude width; defaulted here if the build does not set it.
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 16
`endif

package qft3_prob_readout_pkg;
    localparam int TOTAL_W = `TOTAL_WIDTH;
    localparam int PROB_W  = 2 * TOTAL_W;
    localparam int SUM_W   = 2 * TOTAL_W + 3;
    localparam int IDX_W   = 3;
    localparam int N_BASIS = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;
endpackage

// File: rtl/complex_mag_sq.sv
// Combinational |z|^2 = re^2 + im^2 for signed W-bit components, unsigned PW-bit result.
module complex_mag_sq
    import qft3_prob_readout_pkg::*;
#(
    parameter int W  = TOTAL_W,
    parameter int PW = 2 * W
)(
    input  logic signed [W-1:0]  i_re,
    input  logic signed [W-1:0]  i_im,
    output logic        [PW-1:0] o_mag
);
    logic signed [2*W-1:0] w_re_ext;
    logic signed [2*W-1:0] w_im_ext;
    logic signed [2*W-1:0] w_re_sq;
    logic signed [2*W-1:0] w_im_sq;

    // Sign-extend before squaring so the product is computed at full precision.
    assign w_re_ext = {{W{i_re[W-1]}}, i_re};
    assign w_im_ext = {{W{i_im[W-1]}}, i_im};
    assign w_re_sq  = w_re_ext * w_re_ext;
    assign w_im_sq  = w_im_ext * w_im_ext;
    assign o_mag    = PW'($unsigned(w_re_sq)) + PW'($unsigned(w_im_sq));
endmodule

// File: rtl/qft3_prob_readout.sv
// Captures an 8-amplitude state vector, computes per-basis probabilities with one shared
// squarer, tracks argmax/total power, then streams the probabilities out with backpressure.
module qft3_prob_readout
    import qft3_prob_readout_pkg::*;
#(
    parameter int W  = TOTAL_W,
    parameter int PW = 2 * W,
    parameter int SW = 2 * W + 3
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*W-1:0]      state_r,
    input  logic [8*W-1:0]      state_i,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IDX_W-1:0]    out_idx,
    output logic [PW-1:0]       out_prob,
    output logic                out_last,
    output logic                summary_valid,
    output logic [IDX_W-1:0]    argmax_idx,
    output logic [SW-1:0]       total_power,
    output logic                busy
);
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic signed [W-1:0]    r_cap_re [N_BASIS];
    logic signed [W-1:0]    r_cap_im [N_BASIS];
    logic [PW-1:0]          r_prob   [N_BASIS];
    logic [IDX_W-1:0]       r_k;
    logic [IDX_W-1:0]       r_ptr;
    logic [IDX_W-1:0]       r_amax_work;
    logic [IDX_W-1:0]       r_argmax;
    logic [PW-1:0]          r_max;
    logic [PW-1:0]          r_out_prob;
    logic [SW-1:0]          r_sum;
    logic [SW-1:0]          r_total;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic                   r_summary_valid;
    logic                   r_busy;
    logic [PW-1:0]          w_mag;
    logic                   w_upd;
    logic                   w_calc_done;
    logic                   w_stream_done;

    complex_mag_sq #(.W(W), .PW(PW)) u_mag (
        .i_re  (r_cap_re[r_k]),
        .i_im  (r_cap_im[r_k]),
        .o_mag (w_mag)
    );

    // Strictly-greater compare keeps the lowest index on ties.
    assign w_upd         = (r_k == 3'd0) || (w_mag > r_max);
    assign w_calc_done   = (r_k == 3'd7);
    assign w_stream_done = r_out_valid && out_ready && (r_ptr == 3'd7);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: IDLE -> CALC -> STREAM -> IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) w_state_nxt = ST_CALC;
                else          w_state_nxt = ST_IDLE;
            end
            ST_CALC: begin
                if (w_calc_done) w_state_nxt = ST_STREAM;
                else             w_state_nxt = ST_CALC;
            end
            ST_STREAM: begin
                if (w_stream_done) w_state_nxt = ST_IDLE;
                else               w_state_nxt = ST_STREAM;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: capture, per-index magnitude accumulation, and registered stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_BASIS; k++) begin
                r_cap_re[k] <= '0;
                r_cap_im[k] <= '0;
                r_prob[k]   <= '0;
            end
            r_k             <= 3'd0;
            r_ptr           <= 3'd0;
            r_amax_work     <= 3'd0;
            r_argmax        <= 3'd0;
            r_max           <= '0;
            r_out_prob      <= '0;
            r_sum           <= '0;
            r_total         <= '0;
            r_in_ready      <= 1'b1;
            r_out_valid     <= 1'b0;
            r_summary_valid <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_summary_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < N_BASIS; k++) begin
                            r_cap_re[k] <= $signed(state_r[k*W +: W]);
                            r_cap_im[k] <= $signed(state_i[k*W +: W]);
                        end
                        r_k        <= 3'd0;
                        r_sum      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_CALC: begin
                    r_prob[r_k] <= w_mag;
                    r_sum       <= r_sum + SW'(w_mag);
                    r_k         <= r_k + 3'd1;
                    if (w_upd) begin
                        r_max       <= w_mag;
                        r_amax_work <= r_k;
                    end
                    // Last index: publish summary and present beat 0 (prob[0] was stored at k=0).
                    if (w_calc_done) begin
                        r_argmax        <= w_upd ? r_k : r_amax_work;
                        r_total         <= r_sum + SW'(w_mag);
                        r_summary_valid <= 1'b1;
                        r_out_valid     <= 1'b1;
                        r_ptr           <= 3'd0;
                        r_out_prob      <= r_prob[0];
                    end
                end
                ST_STREAM: begin
                    if (r_out_valid && out_ready) begin
                        if (r_ptr == 3'd7) begin
                            r_out_valid <= 1'b0;
                            r_out_prob  <= '0;
                            r_ptr       <= 3'd0;
                            r_in_ready  <= 1'b1;
                            r_busy      <= 1'b0;
                        end else begin
                            r_ptr      <= r_ptr + 3'd1;
                            r_out_prob <= r_prob[r_ptr + 3'd1];
                        end
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign out_idx       = r_ptr;
    assign out_prob      = r_out_prob;
    assign out_last      = r_out_valid && (r_ptr == 3'd7);
    assign summary_valid = r_summary_valid;
    assign argmax_idx    = r_argmax;
    assign total_power   = r_total;
    assign busy          = r_busy;
endmodule
